vga_image_scanner: RTL and testbench

- Display-side consumer of the CPU's GPU read ports: generates 640x480@60 VGA timing and drives GPUAddress.
- Fetches one pixel per pixel tick from either decrypted RAM (GPUData) or the original image ROM (GPUDataRom).
- Outputs 8-bit grayscale to the board DAC.
- Sits between cpu and the VGA pins; the GPU port is read-only, so it never disturbs CPU memory traffic.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_image_scanner_if.sv | 11 +
 rtl/vga_timing.sv | 52 +++++
 rtl/vga_image_scanner.sv | 154 +++++++++++++++
 tb/tb_vga_image_scanner.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Raster constants for 640x480@60 and the types shared by the image scanner files.
package vga_pkg;
   localparam int H_VIS   = 640;
   localparam int H_FP    = 16;
   localparam int H_SYNC  = 96;
   localparam int H_BP    = 48;
   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_VIS   = 480;
   localparam int V_FP    = 10;
   localparam int V_SYNC  = 2;
   localparam int V_BP    = 33;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   typedef logic [9:0]  hcount_t;
   typedef logic [9:0]  vcount_t;
   typedef logic [31:0] gpu_word_t;
   typedef logic [15:0] gpu_addr_t;

   localparam hcount_t H_LAST    = hcount_t'(H_TOTAL - 1);
   localparam hcount_t H_VIS_END = hcount_t'(H_VIS);
   localparam hcount_t H_SS      = hcount_t'(H_VIS + H_FP);
   localparam hcount_t H_SE      = hcount_t'(H_VIS + H_FP + H_SYNC);
   localparam vcount_t V_LAST    = vcount_t'(V_TOTAL - 1);
   localparam vcount_t V_VIS_END = vcount_t'(V_VIS);
   localparam vcount_t V_SS      = vcount_t'(V_VIS + V_FP);
   localparam vcount_t V_SE      = vcount_t'(V_VIS + V_FP + V_SYNC);
endpackage

// File: rtl/vga_image_scanner_if.sv
// Read-only GPU port between the CPU memories and the image scanner.
interface vga_image_scanner_if;
   import vga_pkg::*;

   gpu_word_t GPUData;
   gpu_word_t GPUDataRom;
   gpu_addr_t GPUAddress;

   modport master (output GPUAddress, input GPUData, input GPUDataRom);
   modport slave  (input GPUAddress, output GPUData, output GPUDataRom);
endinterface

// File: rtl/vga_timing.sv
// Pixel-tick divider plus 800x525 raster counters with raw sync and visible flags.
module vga_timing
   import vga_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic    clk,
   input  logic    rst,
   output logic    tick,
   output logic    pix_clk,
   output hcount_t h,
   output vcount_t v,
   output logic    hs_raw,
   output logic    vs_raw,
   output logic    vis_raw
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div, div_nxt;

   if (CLK_DIV < 2) begin : g_div_chk
      $error("vga_timing: CLK_DIV must be at least 2");
   end

   assign tick    = (div == DW'(CLK_DIV - 1));
   assign div_nxt = tick ? '0 : div + DW'(1);

   // pix_clk is registered from the next divider count so it stays glitch-free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div     <= '0;
         pix_clk <= 1'b0;
         h       <= '0;
         v       <= '0;
      end else begin
         div     <= div_nxt;
         pix_clk <= (div_nxt >= DW'(CLK_DIV / 2));
         if (tick) begin
            if (h == H_LAST) begin
               h <= '0;
               v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
               h <= h + 1'b1;
            end
         end
      end
   end

   assign hs_raw  = !((h >= H_SS) && (h < H_SE));
   assign vs_raw  = !((v >= V_SS) && (v < V_SE));
   assign vis_raw = (h < H_VIS_END) && (v < V_VIS_END);
endmodule

// File: rtl/vga_image_scanner.sv
// VGA scanner: raster timing, incremental image addressing and a 3-stage pixel pipeline
// (S0 counters, S1 address/flags, S2 data/outputs) that keeps pixels aligned with syncs.
module vga_image_scanner
   import vga_pkg::*;
#(
   parameter int         CLK_DIV  = 2,
   parameter int         IMG_W    = 100,
   parameter int         IMG_H    = 100,
   parameter int         SCALE_SH = 2,
   parameter int         X0       = 120,
   parameter int         Y0       = 40,
   parameter logic [7:0] BORDER   = 8'h00
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       src_sel,
   vga_image_scanner_if.master        gpu,
   output logic                       vga_clk,
   output logic                       vga_hs,
   output logic                       vga_vs,
   output logic                       vga_blank_n,
   output logic [7:0]                 vga_r,
   output logic [7:0]                 vga_g,
   output logic [7:0]                 vga_b,
   output logic                       frame_start
);
   localparam int SUB = 1 << SCALE_SH;
   localparam int SW  = SCALE_SH + 1;
   localparam hcount_t WX0 = hcount_t'(X0);
   localparam hcount_t WX1 = hcount_t'(X0 + (IMG_W << SCALE_SH));
   localparam hcount_t WXL = hcount_t'(X0 + (IMG_W << SCALE_SH) - 1);
   localparam vcount_t WY0 = vcount_t'(Y0);
   localparam vcount_t WY1 = vcount_t'(Y0 + (IMG_H << SCALE_SH));
   localparam logic [SW-1:0] SUB_LAST = SW'(SUB - 1);
   localparam gpu_addr_t ROW_STEP = gpu_addr_t'(IMG_W);

   if (IMG_W * IMG_H > 16384) begin : g_size_chk
      $error("vga_image_scanner: IMG_W*IMG_H exceeds 16384");
   end

   function automatic logic [7:0] pix_sel(input logic vld, input logic win, input logic src,
                                          input logic [7:0] ram_px, input logic [7:0] rom_px);
      if (!vld) return 8'h00;
      if (!win) return BORDER;
      return src ? rom_px : ram_px;
   endfunction

   logic    tick, pix_clk, hs_raw, vs_raw, vis_raw;
   hcount_t h;
   vcount_t v;

   vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .pix_clk (pix_clk),
      .h       (h),
      .v       (v),
      .hs_raw  (hs_raw),
      .vs_raw  (vs_raw),
      .vis_raw (vis_raw)
   );

   logic          frame_top, in_win, src_lat;
   gpu_addr_t     row_base, col, rb_cur, col_cur;
   logic [SW-1:0] sx, sy, sx_cur, sy_cur;

   // The "_cur" values apply frame-top and row-start restarts in the same tick they occur
   assign frame_top = (h == '0) && (v == '0);
   assign in_win    = (h >= WX0) && (h < WX1) && (v >= WY0) && (v < WY1);
   assign rb_cur    = frame_top ? '0 : row_base;
   assign sy_cur    = frame_top ? '0 : sy;
   assign sx_cur    = (h == WX0) ? '0 : sx;
   assign col_cur   = (h == WX0) ? '0 : col;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_lat     <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= tick && frame_top;
         if (tick && frame_top) src_lat <= src_sel;
      end
   end

   // S0 -> S1: register address and raster flags
   gpu_addr_t addr_p1;
   logic      in_win_p1, vld_p1, hs_p1, vs_p1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_p1   <= '0;
         row_base  <= '0;
         col       <= '0;
         sx        <= '0;
         sy        <= '0;
         in_win_p1 <= 1'b0;
         vld_p1    <= 1'b0;
         hs_p1     <= 1'b1;
         vs_p1     <= 1'b1;
      end else if (tick) begin
         in_win_p1 <= in_win;
         vld_p1    <= vis_raw;
         hs_p1     <= hs_raw;
         vs_p1     <= vs_raw;
         row_base  <= rb_cur;
         sy        <= sy_cur;
         if (in_win) begin
            addr_p1 <= rb_cur + col_cur;
            sx      <= (sx_cur == SUB_LAST) ? '0 : sx_cur + 1'b1;
            col     <= (sx_cur == SUB_LAST) ? col_cur + 1'b1 : col_cur;
            if (h == WXL) begin
               if (sy_cur == SUB_LAST) begin
                  sy       <= '0;
                  row_base <= rb_cur + ROW_STEP;
               end else begin
                  sy <= sy_cur + 1'b1;
               end
            end
         end
      end
   end

   assign gpu.GPUAddress = addr_p1;

   // S1 -> S2: capture memory data, drive pixel and syncs
   logic [7:0] rgb_p2;
   logic       hs_p2, vs_p2, vld_p2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rgb_p2 <= 8'h00;
         hs_p2  <= 1'b1;
         vs_p2  <= 1'b1;
         vld_p2 <= 1'b0;
      end else if (tick) begin
         rgb_p2 <= pix_sel(vld_p1, in_win_p1, src_lat, gpu.GPUData[7:0], gpu.GPUDataRom[7:0]);
         hs_p2  <= hs_p1;
         vs_p2  <= vs_p1;
         vld_p2 <= vld_p1;
      end
   end

   logic unused_hi;
   assign unused_hi = ^{gpu.GPUData[31:8], gpu.GPUDataRom[31:8]};

   assign vga_clk     = pix_clk;
   assign vga_hs      = hs_p2;
   assign vga_vs      = vs_p2;
   assign vga_blank_n = vld_p2;
   assign vga_r       = rgb_p2;
   assign vga_g       = rgb_p2;
   assign vga_b       = rgb_p2;
endmodule

// File: tb/tb_vga_image_scanner.sv
// Bench for vga_image_scanner: random memory contents, random check points and random
// reset/src_sel timing, compared against a raster model computed from pixel indices.
module tb_vga_image_scanner;
   import vga_pkg::*;

   localparam int         CLK_DIV = 2;
   localparam int         IMG_W   = 100;
   localparam int         IMG_H   = 5;
   localparam int         SH      = 2;
   localparam int         X0      = 120;
   localparam int         Y0      = 4;
   localparam logic [7:0] BORDER  = 8'h5A;
   localparam int         WIN_W   = IMG_W << SH;
   localparam int         WIN_H   = IMG_H << SH;
   localparam int         LINE_CLKS = 800 * CLK_DIV;

   logic       clk, rst, src_sel;
   logic       vga_clk, vga_hs, vga_vs, vga_blank_n, frame_start;
   logic [7:0] vga_r, vga_g, vga_b;
   logic [31:0] ram [0:65535];
   logic [31:0] rom [0:65535];

   vga_image_scanner_if gif ();
   assign gif.GPUData    = ram[gif.GPUAddress];
   assign gif.GPUDataRom = rom[gif.GPUAddress];

   vga_image_scanner #(
      .CLK_DIV(CLK_DIV), .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE_SH(SH),
      .X0(X0), .Y0(Y0), .BORDER(BORDER)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .src_sel     (src_sel),
      .gpu         (gif),
      .vga_clk     (vga_clk),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_blank_n (vga_blank_n),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         h;
      int         v;
      int         addr;
      logic [7:0] ram_px;
      logic [7:0] rom_px;
   } pt_t;
   pt_t pts[$];

   int   total = 0, bad = 0;
   int   n = 0, model_addr = 0;
   int   hs_low, blank_hi, blank_rise, fs_first, fs_cnt;
   int   hs_fall[$];
   logic hs_prev;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, got, exp, n);
      end
   endtask

   function automatic bit in_win(int h, int v);
      return h >= X0 && h < X0 + WIN_W && v >= Y0 && v < Y0 + WIN_H;
   endfunction

   function automatic int pix_addr(int h, int v);
      return ((v - Y0) >> SH) * IMG_W + ((h - X0) >> SH);
   endfunction

   function automatic logic [7:0] exp_rgb(int h, int v, bit src);
      logic [31:0] w;
      if (!(h < 640 && v < 480)) return 8'h00;
      if (!in_win(h, v)) return BORDER;
      w = src ? rom[pix_addr(h, v)] : ram[pix_addr(h, v)];
      return w[7:0];
   endfunction

   function automatic bit is_pt(int h, int v);
      foreach (pts[i]) if (pts[i].h == h && pts[i].v == v) return 1'b1;
      return 1'b0;
   endfunction

   // One clock: outputs after tick k show pixel k-2, GPUAddress shows pixel k-1
   task automatic step_clk(input bit src_exp);
      int k, p, q, ph, pv;
      bit sel;
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n >= 4 && n < 4 + 3 * LINE_CLKS) begin
         if (!vga_hs) hs_low++;
         if (vga_blank_n) blank_hi++;
      end
      if (vga_blank_n && blank_rise < 0) blank_rise = n;
      if (!vga_hs && hs_prev) hs_fall.push_back(n);
      hs_prev = vga_hs;
      if (frame_start) begin
         fs_cnt++;
         if (fs_first < 0) fs_first = n;
      end
      if (n < 8) chk("vga_clk", 32'(vga_clk), 32'(n % 2));
      if (n % 2 == 0) begin
         k = n / 2;
         q = k - 1;
         p = k - 2;
         if (in_win(q % 800, q / 800)) model_addr = pix_addr(q % 800, q / 800);
         foreach (pts[i])
            if (pts[i].addr >= 0 && pts[i].h == q % 800 && pts[i].v == q / 800)
               chk("tbl_addr", 32'(gif.GPUAddress), pts[i].addr);
         if (p >= 0) begin
            ph  = p % 800;
            pv  = p / 800;
            sel = is_pt(ph, pv) || ($urandom_range(0, 127) == 0);
            if (sel) begin
               chk("addr", 32'(gif.GPUAddress), model_addr);
               chk("rgb_r", 32'(vga_r), 32'(exp_rgb(ph, pv, src_exp)));
               chk("rgb_g", 32'(vga_g), 32'(exp_rgb(ph, pv, src_exp)));
               chk("rgb_b", 32'(vga_b), 32'(exp_rgb(ph, pv, src_exp)));
               chk("hs", 32'(vga_hs), 32'(!(ph >= 656 && ph < 752)));
               chk("vs", 32'(vga_vs), 32'(!(pv >= 490 && pv < 492)));
               chk("blank_n", 32'(vga_blank_n), 32'(ph < 640 && pv < 480));
            end
            foreach (pts[i])
               if (pts[i].h == ph && pts[i].v == pv)
                  chk("tbl_rgb", 32'(vga_r), 32'(src_exp ? pts[i].rom_px : pts[i].ram_px));
         end
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst        = 1'b0;
      n          = 0;
      model_addr = 0;
      hs_low     = 0;
      blank_hi   = 0;
      blank_rise = -1;
      fs_first   = -1;
      fs_cnt     = 0;
      hs_prev    = 1'b1;
      hs_fall.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int toggle_at, extra;
      rst     = 1'b1;
      src_sel = 1'b0;
      for (int a = 0; a < 65536; a++) begin
         ram[a] = {24'($urandom), 8'(a)};
         rom[a] = {24'($urandom), ~8'(a)};
      end
      pts.push_back('{120, 4, 0, 8'h00, 8'hFF});
      pts.push_back('{124, 4, 1, 8'h01, 8'hFE});
      pts.push_back('{120, 8, 100, 8'h64, 8'h9B});
      pts.push_back('{519, 23, 499, 8'hF3, 8'h0C});
      pts.push_back('{0, 0, -1, BORDER, BORDER});
      pts.push_back('{700, 0, -1, 8'h00, 8'h00});
      pts.push_back('{119, 4, -1, BORDER, BORDER});
      pts.push_back('{520, 23, -1, BORDER, BORDER});
      pts.push_back('{639, 5, -1, BORDER, BORDER});

      // RAM frame; src_sel flips mid-frame and must not take effect yet
      repeat (3) @(posedge clk);
      release_reset();
      toggle_at = LINE_CLKS * $urandom_range(6, 20) + $urandom_range(0, LINE_CLKS - 1);
      for (int c = 0; c < 25 * LINE_CLKS; c++) begin
         if (n == toggle_at) src_sel = 1'b1;
         step_clk(1'b0);
      end
      chk("fs_first", fs_first, 2);
      chk("fs_count", fs_cnt, 1);
      chk("blank_rise", blank_rise, 4);
      chk("hs_low_clks", hs_low, 3 * 96 * CLK_DIV);
      chk("blank_hi_clks", blank_hi, 3 * 640 * CLK_DIV);
      chk("hs_fall_seen", 32'(hs_fall.size() >= 2), 1);
      if (hs_fall.size() >= 2) begin
         chk("hs_fall_first", hs_fall[0], (656 + 2) * CLK_DIV);
         chk("line_period", hs_fall[1] - hs_fall[0], LINE_CLKS);
      end

      // asynchronous reset in the middle of a line
      extra = $urandom_range(100, 1500);
      repeat (extra) step_clk(1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_addr", 32'(gif.GPUAddress), 0);
      chk("rst_vga_clk", 32'(vga_clk), 0);
      chk("rst_hs", 32'(vga_hs), 1);
      chk("rst_vs", 32'(vga_vs), 1);
      chk("rst_blank_n", 32'(vga_blank_n), 0);
      chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
      chk("rst_frame_start", 32'(frame_start), 0);

      // new frame after release latches src_sel=1, so window pixels come from ROM
      src_sel = 1'b1;
      repeat (3) @(posedge clk);
      release_reset();
      repeat (9 * LINE_CLKS) step_clk(1'b1);
      chk("fs_first_2", fs_first, 2);
      chk("fs_count_2", fs_cnt, 1);
      chk("blank_rise_2", blank_rise, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
